// File: rtl/cpu_mem_pkg.sv
// rtl/cpu_mem_pkg.sv - shared widths, FSM encoding and requester ids for the RAM arbiter
package cpu_mem_pkg;

    localparam int DEF_ADDR_W = 9;
    localparam int DEF_DATA_W = 32;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_ACK   = 2'd3
    } state_t;

    localparam logic REQ_CPU = 1'b0;
    localparam logic REQ_LDR = 1'b1;

    // WAIT counter preload: WAIT lasts LAT cycles, ending when the count reaches 0
    function automatic logic [1:0] lat_preload(input int lat);
        return 2'(lat - 1);
    endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// rtl/rr_arbiter2.sv - two-way round-robin arbiter with one-hot grant and last_grant memory
module rr_arbiter2
    import cpu_mem_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       update,
    output logic [1:0] grant
);

    logic last_grant;

    always_comb begin
        grant = req;
        if (req[REQ_CPU] && req[REQ_LDR]) begin
            grant = (last_grant == REQ_LDR) ? 2'b01 : 2'b10;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_grant <= REQ_LDR;
        end else if (update && (grant != 2'b00)) begin
            last_grant <= grant[REQ_LDR] ? REQ_LDR : REQ_CPU;
        end
    end

endmodule

// File: rtl/mem_access_arbiter.sv
// rtl/mem_access_arbiter.sv - shares one RAM port between CPU and loader with fixed-latency sequencing
module mem_access_arbiter
    import cpu_mem_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W,
    parameter int RD_LAT = 1,
    parameter int WR_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_ack,
    output logic [DATA_W-1:0] cpu_rdata,
    input  logic              ldr_req,
    input  logic              ldr_we,
    input  logic [ADDR_W-1:0] ldr_addr,
    input  logic [DATA_W-1:0] ldr_wdata,
    output logic              ldr_ack,
    output logic [DATA_W-1:0] ldr_rdata,
    output logic              ram_en,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic              busy
);

    if (RD_LAT < 1 || RD_LAT > 3) begin : g_bad_rd_lat
        $error("mem_access_arbiter: RD_LAT must be 1..3");
    end
    if (WR_LAT < 1 || WR_LAT > 3) begin : g_bad_wr_lat
        $error("mem_access_arbiter: WR_LAT must be 1..3");
    end

    localparam logic [1:0] RD_CNT = lat_preload(RD_LAT);
    localparam logic [1:0] WR_CNT = lat_preload(WR_LAT);

    state_t     state;
    logic [1:0] cnt;
    logic       owner;
    logic [1:0] grant;

    rr_arbiter2 u_arb (
        .clk    (clk),
        .rst    (rst),
        .req    ({ldr_req, cpu_req}),
        .update (state == ST_IDLE),
        .grant  (grant)
    );

    assign busy = (state != ST_IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            cnt       <= 2'd0;
            owner     <= REQ_CPU;
            ram_en    <= 1'b0;
            ram_we    <= 1'b0;
            ram_addr  <= '0;
            ram_wdata <= '0;
            cpu_ack   <= 1'b0;
            ldr_ack   <= 1'b0;
            cpu_rdata <= '0;
            ldr_rdata <= '0;
        end else begin
            ram_en  <= 1'b0;
            cpu_ack <= 1'b0;
            ldr_ack <= 1'b0;
            case (state)
                ST_IDLE: begin
                    // operands are latched once here; later input changes are ignored
                    if (grant != 2'b00) begin
                        owner     <= grant[REQ_LDR];
                        ram_we    <= grant[REQ_LDR] ? ldr_we    : cpu_we;
                        ram_addr  <= grant[REQ_LDR] ? ldr_addr  : cpu_addr;
                        ram_wdata <= grant[REQ_LDR] ? ldr_wdata : cpu_wdata;
                        ram_en    <= 1'b1;
                        state     <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    cnt   <= ram_we ? WR_CNT : RD_CNT;
                    state <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (cnt == 2'd0) begin
                        state <= ST_ACK;
                        if (owner == REQ_LDR) begin
                            ldr_ack <= 1'b1;
                            if (!ram_we) ldr_rdata <= ram_rdata;
                        end else begin
                            cpu_ack <= 1'b1;
                            if (!ram_we) cpu_rdata <= ram_rdata;
                        end
                    end else begin
                        cnt <= cnt - 2'd1;
                    end
                end
                ST_ACK: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_arbiter.sv
// tb/tb_mem_access_arbiter.sv - self-checking bench for mem_access_arbiter with RAM models and scoreboard
module tb_mem_access_arbiter;

    logic clk;
    logic rst;

    logic        a_cpu_req, a_cpu_we, a_cpu_ack, a_ldr_req, a_ldr_we, a_ldr_ack;
    logic [8:0]  a_cpu_addr, a_ldr_addr, a_ram_addr;
    logic [31:0] a_cpu_wdata, a_cpu_rdata, a_ldr_wdata, a_ldr_rdata;
    logic        a_ram_en, a_ram_we, a_busy;
    logic [31:0] a_ram_wdata, a_ram_rdata, a_p0;

    logic        b_cpu_req, b_cpu_we, b_cpu_ack, b_ldr_ack;
    logic [8:0]  b_cpu_addr, b_ram_addr;
    logic [31:0] b_cpu_wdata, b_cpu_rdata, b_ldr_rdata;
    logic        b_ram_en, b_ram_we, b_busy;
    logic [31:0] b_ram_wdata, b_ram_rdata, b_p0, b_p1, b_p2;

    logic [31:0] mem_a [512];
    logic [31:0] mem_b [512];

    int checks = 0;
    int passed = 0;

    typedef struct {
        bit          port;
        bit          we;
        logic [31:0] exp;
    } sb_t;
    sb_t         sb_q[$];
    logic [31:0] last_rd [2];

    typedef struct {
        bit          port;
        bit          we;
        logic [8:0]  addr;
        logic [31:0] wdata;
        logic [31:0] exp_rd;
        int          lat;
    } vec_t;
    vec_t vecs[7];

    mem_access_arbiter #(.ADDR_W(9), .DATA_W(32), .RD_LAT(1), .WR_LAT(2)) dut_a (
        .clk(clk), .rst(rst),
        .cpu_req(a_cpu_req), .cpu_we(a_cpu_we), .cpu_addr(a_cpu_addr), .cpu_wdata(a_cpu_wdata),
        .cpu_ack(a_cpu_ack), .cpu_rdata(a_cpu_rdata),
        .ldr_req(a_ldr_req), .ldr_we(a_ldr_we), .ldr_addr(a_ldr_addr), .ldr_wdata(a_ldr_wdata),
        .ldr_ack(a_ldr_ack), .ldr_rdata(a_ldr_rdata),
        .ram_en(a_ram_en), .ram_we(a_ram_we), .ram_addr(a_ram_addr), .ram_wdata(a_ram_wdata),
        .ram_rdata(a_ram_rdata), .busy(a_busy)
    );

    mem_access_arbiter #(.ADDR_W(9), .DATA_W(32), .RD_LAT(3), .WR_LAT(1)) dut_b (
        .clk(clk), .rst(rst),
        .cpu_req(b_cpu_req), .cpu_we(b_cpu_we), .cpu_addr(b_cpu_addr), .cpu_wdata(b_cpu_wdata),
        .cpu_ack(b_cpu_ack), .cpu_rdata(b_cpu_rdata),
        .ldr_req(1'b0), .ldr_we(1'b0), .ldr_addr(9'h0), .ldr_wdata(32'h0),
        .ldr_ack(b_ldr_ack), .ldr_rdata(b_ldr_rdata),
        .ram_en(b_ram_en), .ram_we(b_ram_we), .ram_addr(b_ram_addr), .ram_wdata(b_ram_wdata),
        .ram_rdata(b_ram_rdata), .busy(b_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RAM models: read data is valid for exactly one cycle, RD_LAT cycles after ram_en
    always @(posedge clk) begin
        a_p0 <= (a_ram_en && !a_ram_we) ? mem_a[a_ram_addr] : 32'h0;
        if (a_ram_en && a_ram_we) mem_a[a_ram_addr] <= a_ram_wdata;
        b_p0 <= (b_ram_en && !b_ram_we) ? mem_b[b_ram_addr] : 32'h0;
        b_p1 <= b_p0;
        b_p2 <= b_p1;
        if (b_ram_en && b_ram_we) mem_b[b_ram_addr] <= b_ram_wdata;
    end
    assign a_ram_rdata = a_p0;
    assign b_ram_rdata = b_p2;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic sb_push(input bit port, input bit we, input logic [31:0] rd);
        sb_t e;
        if (!we) last_rd[port] = rd;
        e.port = port;
        e.we   = we;
        e.exp  = last_rd[port];
        sb_q.push_back(e);
    endtask

    always @(negedge clk) begin
        sb_t e;
        if (a_cpu_ack || a_ldr_ack) begin
            if (sb_q.size() == 0) begin
                chk("unexpected ack", 32'({a_ldr_ack, a_cpu_ack}), 32'h0);
            end else begin
                e = sb_q.pop_front();
                chk("sb ack port", 32'({a_ldr_ack, a_cpu_ack}), e.port ? 32'h2 : 32'h1);
                chk("sb rdata", e.port ? a_ldr_rdata : a_cpu_rdata, e.exp);
            end
        end
    end

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        last_rd[0] = 32'h0;
        last_rd[1] = 32'h0;
    endtask

    task automatic do_access(input bit port, input bit we, input logic [8:0] addr,
                             input logic [31:0] wdata, input logic [31:0] exp_rd,
                             input int exp_lat, input string name);
        int en_k;
        int ack_k;
        logic en_we;
        logic [8:0] en_addr;
        @(negedge clk);
        if (port) begin
            a_ldr_req = 1'b1; a_ldr_we = we; a_ldr_addr = addr; a_ldr_wdata = wdata;
        end else begin
            a_cpu_req = 1'b1; a_cpu_we = we; a_cpu_addr = addr; a_cpu_wdata = wdata;
        end
        sb_push(port, we, exp_rd);
        en_k = -1; ack_k = -1; en_we = 1'b0; en_addr = 9'h0;
        for (int k = 1; k <= 30 && ack_k < 0; k++) begin
            @(negedge clk);
            if (a_ram_en && en_k < 0) begin
                en_k = k; en_we = a_ram_we; en_addr = a_ram_addr;
            end
            if (port ? a_ldr_ack : a_cpu_ack) ack_k = k;
        end
        if (port) a_ldr_req = 1'b0;
        else      a_cpu_req = 1'b0;
        chk({name, " ram_en cycle"}, en_k, 1);
        chk({name, " ram_we"}, 32'(en_we), 32'(we));
        chk({name, " ram_addr"}, 32'(en_addr), 32'(addr));
        chk({name, " ack cycle"}, ack_k, exp_lat);
    endtask

    task automatic b_access(input bit we, input logic [8:0] addr, input logic [31:0] wdata,
                            output int ack_k, output logic [31:0] rd);
        @(negedge clk);
        b_cpu_req = 1'b1; b_cpu_we = we; b_cpu_addr = addr; b_cpu_wdata = wdata;
        ack_k = -1; rd = 32'h0;
        for (int k = 1; k <= 30 && ack_k < 0; k++) begin
            @(negedge clk);
            if (b_cpu_ack) begin
                ack_k = k; rd = b_cpu_rdata;
            end
        end
        b_cpu_req = 1'b0;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        int n;
        int ack_k;
        int en2;
        int acks[2];
        logic [3:0]  ord;
        logic [15:0] busy_v;
        logic [31:0] rd;

        rst = 1'b1;
        a_cpu_req = 0; a_cpu_we = 0; a_cpu_addr = 0; a_cpu_wdata = 0;
        a_ldr_req = 0; a_ldr_we = 0; a_ldr_addr = 0; a_ldr_wdata = 0;
        b_cpu_req = 0; b_cpu_we = 0; b_cpu_addr = 0; b_cpu_wdata = 0;
        last_rd[0] = 32'h0; last_rd[1] = 32'h0;
        for (int i = 0; i < 512; i++) begin
            mem_a[i] = 32'hA500_0000 | 32'(i);
            mem_b[i] = 32'hA500_0000 | 32'(i);
        end
        mem_a[16] = 32'hDEAD_BEEF;

        vecs[0] = '{port: 1'b0, we: 1'b0, addr: 9'h010, wdata: 32'h0,         exp_rd: 32'hDEAD_BEEF, lat: 3};
        vecs[1] = '{port: 1'b1, we: 1'b1, addr: 9'h1FF, wdata: 32'h1234_5678, exp_rd: 32'h0,         lat: 4};
        vecs[2] = '{port: 1'b0, we: 1'b0, addr: 9'h1FF, wdata: 32'h0,         exp_rd: 32'h1234_5678, lat: 3};
        vecs[3] = '{port: 1'b1, we: 1'b0, addr: 9'h010, wdata: 32'h0,         exp_rd: 32'hDEAD_BEEF, lat: 3};
        vecs[4] = '{port: 1'b0, we: 1'b1, addr: 9'h005, wdata: 32'hCAFE_F00D, exp_rd: 32'h0,         lat: 4};
        vecs[5] = '{port: 1'b1, we: 1'b0, addr: 9'h005, wdata: 32'h0,         exp_rd: 32'hCAFE_F00D, lat: 3};
        vecs[6] = '{port: 1'b0, we: 1'b0, addr: 9'h100, wdata: 32'h0,         exp_rd: 32'hA500_0100, lat: 3};

        @(negedge clk);
        chk("reset outputs", 32'({a_cpu_ack, a_ldr_ack, a_ram_en, a_ram_we, a_busy, a_ram_addr}), 32'h0);
        chk("reset rdata", a_cpu_rdata | a_ldr_rdata | a_ram_wdata, 32'h0);
        rst = 1'b0;

        for (int i = 0; i < 7; i++) begin
            do_access(vecs[i].port, vecs[i].we, vecs[i].addr, vecs[i].wdata,
                      vecs[i].exp_rd, vecs[i].lat, $sformatf("vec%0d", i));
        end

        // operands change one cycle after grant; the RAM must only ever see 0x020
        @(negedge clk);
        a_cpu_req = 1'b1; a_cpu_we = 1'b1; a_cpu_addr = 9'h020; a_cpu_wdata = 32'h55AA_55AA;
        sb_push(1'b0, 1'b1, 32'h0);
        @(negedge clk);
        chk("t5 ram_en", 32'(a_ram_en), 32'h1);
        chk("t5 ram_addr", 32'(a_ram_addr), 32'h020);
        a_cpu_addr = 9'h030; a_cpu_wdata = 32'h0;
        ack_k = -1;
        for (int k = 2; k <= 30 && ack_k < 0; k++) begin
            @(negedge clk);
            if (a_cpu_ack) ack_k = k;
        end
        a_cpu_req = 1'b0;
        chk("t5 ack cycle", ack_k, 4);
        chk("t5 ram_addr hold", 32'(a_ram_addr), 32'h020);
        do_access(1'b0, 1'b0, 9'h030, 32'h0, 32'hA500_0030, 3, "t5 rd030");
        do_access(1'b1, 1'b0, 9'h020, 32'h0, 32'h55AA_55AA, 3, "t5 rd020");

        // simultaneous requests right after reset, then held for four grants
        do_reset();
        @(negedge clk);
        a_cpu_req = 1'b1; a_cpu_we = 1'b0; a_cpu_addr = 9'h010;
        a_ldr_req = 1'b1; a_ldr_we = 1'b0; a_ldr_addr = 9'h1FF;
        sb_push(1'b0, 1'b0, 32'hDEAD_BEEF);
        sb_push(1'b1, 1'b0, 32'h1234_5678);
        sb_push(1'b0, 1'b0, 32'hDEAD_BEEF);
        sb_push(1'b1, 1'b0, 32'h1234_5678);
        n = 0; ord = 4'h0;
        for (int k = 0; k < 80 && n < 4; k++) begin
            @(negedge clk);
            if (a_cpu_ack || a_ldr_ack) begin
                ord[n] = a_ldr_ack;
                n++;
            end
        end
        a_cpu_req = 1'b0; a_ldr_req = 1'b0;
        chk("t4 ack count", n, 4);
        chk("t4 grant order", 32'(ord), 32'h0000_000A);

        // reset in the middle of a loader write's WAIT phase
        @(negedge clk);
        a_ldr_req = 1'b1; a_ldr_we = 1'b1; a_ldr_addr = 9'h0AA; a_ldr_wdata = 32'h0;
        repeat (2) @(negedge clk);
        chk("t1 busy before reset", 32'(a_busy), 32'h1);
        rst = 1'b1;
        #1;
        chk("t1 async drop", 32'({a_ram_en, a_cpu_ack, a_ldr_ack, a_busy}), 32'h0);
        a_ldr_req = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        last_rd[0] = 32'h0; last_rd[1] = 32'h0;
        n = 0;
        repeat (8) begin
            @(negedge clk);
            if (a_cpu_ack || a_ldr_ack) n++;
        end
        chk("t1 no ack after reset", n, 0);
        chk("t1 rdata cleared", a_ldr_rdata, 32'h0);

        // RD_LAT=3 with the request held across two transactions
        @(negedge clk);
        b_cpu_req = 1'b1; b_cpu_we = 1'b0; b_cpu_addr = 9'h040;
        n = 0; busy_v = 16'h0; en2 = -1; acks[0] = -1; acks[1] = -1;
        for (int k = 1; k <= 20 && n < 2; k++) begin
            @(negedge clk);
            busy_v[k] = b_busy;
            if (b_ram_en && k > 1 && en2 < 0) en2 = k;
            if (b_cpu_ack) begin
                acks[n] = k;
                chk("t6 rdata", b_cpu_rdata, 32'hA500_0040);
                n++;
            end
        end
        b_cpu_req = 1'b0;
        chk("t6 first ack", acks[0], 5);
        chk("t6 second ram_en", en2, 7);
        chk("t6 second ack", acks[1], 11);
        chk("t6 busy t1..t6", 32'(busy_v[6:1]), 32'h1F);
        chk("t6 busy t7..t11", 32'(busy_v[11:7]), 32'h1F);
        chk("t6 ldr quiet", 32'({b_ldr_ack, b_ldr_rdata != 32'h0}), 32'h0);

        b_access(1'b1, 9'h041, 32'h0BAD_F00D, ack_k, rd);
        chk("t6 wr lat1 ack", ack_k, 3);
        chk("t6 wr keeps rdata", rd, 32'hA500_0040);
        b_access(1'b0, 9'h041, 32'h0, ack_k, rd);
        chk("t6 rd lat3 ack", ack_k, 5);
        chk("t6 rd back", rd, 32'h0BAD_F00D);

        repeat (2) @(negedge clk);
        chk("sb drained", sb_q.size(), 0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
